// File: rtl/rotary_quad_decoder_if.sv
// Encoder channel inputs and decoded step outputs of the rotary decoder.
interface rotary_quad_decoder_if;
    logic       rota;
    logic       rotb;
    logic       rot_event;
    logic       rot_dir;
    logic [7:0] step_count;
    logic       err;

    // Encoder side: drives the raw channels and observes the decoded outputs.
    modport master (
        output rota,
        output rotb,
        input  rot_event,
        input  rot_dir,
        input  step_count,
        input  err
    );

    // Decoder side.
    modport slave (
        input  rota,
        input  rotb,
        output rot_event,
        output rot_dir,
        output step_count,
        output err
    );
endinterface

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: two-flop sync, per-channel debounce, full
// quadrature decode into single-cycle step events, direction and position.
//
// state    | meaning
// ---------+---------------------------------------------------------
// REST     | filtered pair at 11, no step in progress
// CW1      | 01 seen, clockwise step started
// CW2      | 00 seen on the clockwise path
// CW3      | 10 seen, clockwise step completes on return to 11
// CCW1     | 10 seen, counter-clockwise step started
// CCW2     | 00 seen on the counter-clockwise path
// CCW3     | 01 seen, counter-clockwise step completes on return to 11
// ABORT    | illegal double-bit change seen, waiting for 11
module rotary_quad_decoder #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    rotary_quad_decoder_if.slave bus
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    localparam logic [2:0] ST_REST  = 3'd0;
    localparam logic [2:0] ST_CW1   = 3'd1;
    localparam logic [2:0] ST_CW2   = 3'd2;
    localparam logic [2:0] ST_CW3   = 3'd3;
    localparam logic [2:0] ST_CCW1  = 3'd4;
    localparam logic [2:0] ST_CCW2  = 3'd5;
    localparam logic [2:0] ST_CCW3  = 3'd6;
    localparam logic [2:0] ST_ABORT = 3'd7;

    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      synced;     // {A, B}
    logic [1:0]      filt;       // {A, B}
    logic [DB_W-1:0] db_cnt [2];

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       step_cw;
    logic       step_ccw;
    logic       illegal;

    assign synced = {sync_a[1], sync_b[1]};

    // Two-flop synchronisers; rest level is high so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= {sync_a[0], bus.rota};
            sync_b <= {sync_b[0], bus.rotb};
        end
    end

    // Per-channel debounce: filtered value follows only after DB_CYCLES
    // consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt      <= 2'b11;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (synced[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= synced[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Quadrature next-state: forward, backtrack, completion or illegal jump.
    always_comb begin
        state_nxt = state;
        step_cw   = 1'b0;
        step_ccw  = 1'b0;
        illegal   = 1'b0;
        case (state)
            ST_REST: begin
                case (filt)
                    2'b01:   state_nxt = ST_CW1;
                    2'b10:   state_nxt = ST_CCW1;
                    2'b00:   illegal   = 1'b1;
                    default: state_nxt = ST_REST;
                endcase
            end
            ST_CW1: begin
                case (filt)
                    2'b00:   state_nxt = ST_CW2;
                    2'b11:   state_nxt = ST_REST;
                    2'b10:   illegal   = 1'b1;
                    default: state_nxt = ST_CW1;
                endcase
            end
            ST_CW2: begin
                case (filt)
                    2'b10:   state_nxt = ST_CW3;
                    2'b01:   state_nxt = ST_CW1;
                    2'b11:   illegal   = 1'b1;
                    default: state_nxt = ST_CW2;
                endcase
            end
            ST_CW3: begin
                case (filt)
                    2'b11: begin
                        state_nxt = ST_REST;
                        step_cw   = 1'b1;
                    end
                    2'b00:   state_nxt = ST_CW2;
                    2'b01:   illegal   = 1'b1;
                    default: state_nxt = ST_CW3;
                endcase
            end
            ST_CCW1: begin
                case (filt)
                    2'b00:   state_nxt = ST_CCW2;
                    2'b11:   state_nxt = ST_REST;
                    2'b01:   illegal   = 1'b1;
                    default: state_nxt = ST_CCW1;
                endcase
            end
            ST_CCW2: begin
                case (filt)
                    2'b01:   state_nxt = ST_CCW3;
                    2'b10:   state_nxt = ST_CCW1;
                    2'b11:   illegal   = 1'b1;
                    default: state_nxt = ST_CCW2;
                endcase
            end
            ST_CCW3: begin
                case (filt)
                    2'b11: begin
                        state_nxt = ST_REST;
                        step_ccw  = 1'b1;
                    end
                    2'b00:   state_nxt = ST_CCW2;
                    2'b10:   illegal   = 1'b1;
                    default: state_nxt = ST_CCW3;
                endcase
            end
            default: begin
                if (filt == 2'b11) state_nxt = ST_REST;
            end
        endcase
        if (illegal) state_nxt = ST_ABORT;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_REST;
        else     state <= state_nxt;
    end

    // Registered outputs; event, direction and count move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rot_event  <= 1'b0;
            bus.rot_dir    <= 1'b0;
            bus.step_count <= 8'h00;
            bus.err        <= 1'b0;
        end else begin
            bus.rot_event <= step_cw | step_ccw;
            if (step_cw) begin
                bus.rot_dir    <= 1'b1;
                bus.step_count <= bus.step_count + 8'd1;
            end else if (step_ccw) begin
                bus.rot_dir    <= 1'b0;
                bus.step_count <= bus.step_count - 8'd1;
            end
            if (illegal) bus.err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Self-checking bench for rotary_quad_decoder with an event scoreboard.
module tb_rotary_quad_decoder;

    typedef struct {
        logic       dir;
        logic [7:0] count;
    } exp_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rotary_quad_decoder_if bus();

    rotary_quad_decoder #(.DB_CYCLES(16), .DB_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         ev_total = 0;
    exp_ev_t    exp_q[$];
    logic [7:0] exp_count = 8'h00;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rot_event pops one expected step.
    always @(posedge clk) begin
        exp_ev_t e;
        #1;
        if (bus.rot_event === 1'b1) begin
            ev_total++;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_dir", {31'd0, bus.rot_dir}, {31'd0, e.dir});
                chk("ev_count", {24'd0, bus.step_count}, {24'd0, e.count});
            end
        end
    end

    // Callers sit 1 time unit after a rising edge.
    task automatic phase(input logic a, input logic b, input int n);
        bus.rota = a;
        bus.rotb = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic dir);
        exp_ev_t e;
        exp_count = dir ? exp_count + 8'd1 : exp_count - 8'd1;
        e.dir   = dir;
        e.count = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic cw_step();
        phase(1'b0, 1'b1, 40);
        phase(1'b0, 1'b0, 40);
        phase(1'b1, 1'b0, 40);
        push_ev(1'b1);
        phase(1'b1, 1'b1, 40);
    endtask

    task automatic ccw_step();
        phase(1'b1, 1'b0, 40);
        phase(1'b0, 1'b0, 40);
        phase(1'b0, 1'b1, 40);
        push_ev(1'b0);
        phase(1'b1, 1'b1, 40);
    endtask

    task automatic do_reset(input logic a, input logic b);
        rst      = 1'b1;
        bus.rota = a;
        bus.rotb = b;
        exp_q.delete();
        exp_count = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ev0;
        int lat;

        // Reset state and one clean CW step with latency measurement.
        do_reset(1'b1, 1'b1);
        chk("rst_event", {31'd0, bus.rot_event}, 32'd0);
        chk("rst_dir", {31'd0, bus.rot_dir}, 32'd0);
        chk("rst_count", {24'd0, bus.step_count}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        ev0 = ev_total;
        phase(1'b0, 1'b1, 40);
        phase(1'b0, 1'b0, 40);
        phase(1'b1, 1'b0, 40);
        push_ev(1'b1);
        bus.rota = 1'b1;
        bus.rotb = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.rot_event === 1'b1 && lat < 0) lat = n;
        end
        chk("cw_latency", lat, 32'd19);
        chk("cw_events", ev_total - ev0, 32'd1);
        chk("cw_dir", {31'd0, bus.rot_dir}, 32'd1);
        chk("cw_count", {24'd0, bus.step_count}, 32'h01);
        chk("cw_err", {31'd0, bus.err}, 32'd0);

        // Three CCW steps wrapping below zero.
        do_reset(1'b1, 1'b1);
        ev0 = ev_total;
        for (int k = 0; k < 3; k++) ccw_step();
        chk("ccw_events", ev_total - ev0, 32'd3);
        chk("ccw_dir", {31'd0, bus.rot_dir}, 32'd0);
        chk("ccw_count", {24'd0, bus.step_count}, 32'hFD);

        // Bouncing A settles at 0, then the step completes.
        ev0 = ev_total;
        bus.rotb = 1'b1;
        for (int k = 0; k < 12; k++) phase(~bus.rota, 1'b1, 5);
        phase(1'b0, 1'b1, 40);
        phase(1'b0, 1'b0, 40);
        phase(1'b1, 1'b0, 40);
        push_ev(1'b1);
        phase(1'b1, 1'b1, 40);
        chk("bounce_events", ev_total - ev0, 32'd1);
        chk("bounce_count", {24'd0, bus.step_count}, 32'hFE);

        // Short glitch is filtered out.
        ev0 = ev_total;
        phase(1'b0, 1'b1, 15);
        phase(1'b1, 1'b1, 60);
        chk("glitch_events", ev_total - ev0, 32'd0);
        chk("glitch_count", {24'd0, bus.step_count}, 32'hFE);

        // Backtracking produces no event.
        ev0 = ev_total;
        phase(1'b0, 1'b1, 40);
        phase(1'b0, 1'b0, 40);
        phase(1'b0, 1'b1, 40);
        phase(1'b1, 1'b1, 40);
        phase(1'b0, 1'b1, 40);
        phase(1'b1, 1'b1, 40);
        chk("back_events", ev_total - ev0, 32'd0);
        chk("back_count", {24'd0, bus.step_count}, 32'hFE);
        chk("back_err", {31'd0, bus.err}, 32'd0);

        // Illegal double change sets sticky err; decoding resumes afterwards.
        ev0 = ev_total;
        phase(1'b0, 1'b0, 40);
        chk("illegal_err", {31'd0, bus.err}, 32'd1);
        chk("illegal_events", ev_total - ev0, 32'd0);
        phase(1'b1, 1'b1, 40);
        cw_step();
        chk("recover_events", ev_total - ev0, 32'd1);
        chk("recover_count", {24'd0, bus.step_count}, 32'hFF);
        chk("recover_err", {31'd0, bus.err}, 32'd1);
        cw_step();
        chk("wrap_up_count", {24'd0, bus.step_count}, 32'h00);

        // Reset while in CW2 discards the partial step.
        do_reset(1'b1, 1'b1);
        cw_step();
        phase(1'b0, 1'b1, 40);
        phase(1'b0, 1'b0, 40);
        ev0 = ev_total;
        rst = 1'b1;
        #1;
        chk("midrst_count", {24'd0, bus.step_count}, 32'h00);
        chk("midrst_dir", {31'd0, bus.rot_dir}, 32'd0);
        chk("midrst_event", {31'd0, bus.rot_event}, 32'd0);
        do_reset(1'b1, 1'b0);
        phase(1'b1, 1'b0, 40);
        phase(1'b1, 1'b1, 60);
        chk("midrst_no_event", ev_total - ev0, 32'd0);
        chk("midrst_err", {31'd0, bus.err}, 32'd0);
        cw_step();
        chk("midrst_restart_count", {24'd0, bus.step_count}, 32'h01);

        // Power-up with both channels low flags err, then recovers.
        do_reset(1'b0, 1'b0);
        phase(1'b0, 1'b0, 40);
        chk("pwrup_err", {31'd0, bus.err}, 32'd1);
        phase(1'b1, 1'b1, 40);
        cw_step();
        chk("pwrup_count", {24'd0, bus.step_count}, 32'h01);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
